router_src_tx: RTL and testbench

ROUTER_SRC_TX -- requirements
Module: router_src_tx

---
 rtl/router_src_tx.sv | 197 +++++++++++++++++++
 tb/tb_router_src_tx.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_src_tx.sv
// Serial packet source: 2-bit address, grant wait, LSB-first payload, one-cycle gap.
// Optional grant-wait timeout is built when ROUTER_SRC_TX_TIMEOUT_EN is defined.
module router_src_tx #(
   parameter int GNT_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_start,
   input  logic [1:0] i_dst,
   input  logic [3:0] i_len,
   input  logic [7:0] i_byte,
   input  logic       i_byte_valid,
   output logic       o_byte_ready,
   input  logic       i_gnt,
   output logic       o_frame,
   output logic       o_data,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_underrun,
   output logic       o_abort,
   output logic [2:0] o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_WAIT = 3'd2,
      S_DATA = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   state_t     r_state;
   logic [1:0] r_dst;
   logic [3:0] r_len;
   logic [7:0] r_buf;
   logic       r_buf_vld;
   logic [2:0] r_bit_cnt;
   logic [3:0] r_byte_cnt;
   logic       r_byte_ready;
   logic       r_frame;
   logic       r_data;
   logic       r_done;
   logic       r_underrun;

   // Byte handshake: a byte moves on a rising edge where o_byte_ready and
   // i_byte_valid are both high; i_byte must be stable while i_byte_valid is high.
   logic w_take;
   logic w_last;
   assign w_take = r_byte_ready & i_byte_valid;
   assign w_last = (r_byte_cnt == (r_len - 4'd1));

`ifdef ROUTER_SRC_TX_TIMEOUT_EN
   localparam int WAIT_W = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic              r_abort;
   assign o_abort = r_abort;
`else
   // Without the timeout build the parameter has no consumer.
   logic w_unused_timeout;
   assign w_unused_timeout = (GNT_TIMEOUT > 0);
   assign o_abort = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_dst        <= '0;
         r_len        <= '0;
         r_buf        <= '0;
         r_buf_vld    <= 1'b0;
         r_bit_cnt    <= '0;
         r_byte_cnt   <= '0;
         r_byte_ready <= 1'b0;
         r_frame      <= 1'b0;
         r_data       <= 1'b0;
         r_done       <= 1'b0;
         r_underrun   <= 1'b0;
`ifdef ROUTER_SRC_TX_TIMEOUT_EN
         r_wait_cnt   <= '0;
         r_abort      <= 1'b0;
`endif
      end else begin
         r_done     <= 1'b0;
         r_underrun <= 1'b0;
`ifdef ROUTER_SRC_TX_TIMEOUT_EN
         r_abort    <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_dst      <= i_dst;
                  r_len      <= i_len;
                  r_bit_cnt  <= 3'd0;
                  r_byte_cnt <= 4'd0;
                  r_buf_vld  <= 1'b0;
                  r_frame    <= 1'b1;
                  r_data     <= i_dst[0];
                  r_state    <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (r_bit_cnt == 3'd0) begin
                  r_bit_cnt <= 3'd1;
                  r_data    <= r_dst[1];
               end else begin
                  r_bit_cnt    <= 3'd0;
                  r_data       <= 1'b0;
                  r_byte_ready <= (r_len != 4'd0);
                  r_state      <= S_WAIT;
`ifdef ROUTER_SRC_TX_TIMEOUT_EN
                  r_wait_cnt   <= '0;
`endif
               end
            end
            S_WAIT: begin
               if (w_take) begin
                  r_buf        <= i_byte;
                  r_buf_vld    <= 1'b1;
                  r_byte_ready <= 1'b0;
               end
               // A byte handshaking on the grant edge counts as buffered.
               if (i_gnt) begin
                  r_byte_ready <= 1'b0;
                  if (r_len == 4'd0) begin
                     r_state <= S_GAP;
                     r_frame <= 1'b0;
                     r_data  <= 1'b0;
                     r_done  <= 1'b1;
                  end else if (r_buf_vld || w_take) begin
                     r_state    <= S_DATA;
                     r_data     <= r_buf_vld ? r_buf[0] : i_byte[0];
                     r_bit_cnt  <= 3'd0;
                     r_byte_cnt <= 4'd0;
                  end else begin
                     r_state    <= S_GAP;
                     r_frame    <= 1'b0;
                     r_data     <= 1'b0;
                     r_underrun <= 1'b1;
                  end
               end
`ifdef ROUTER_SRC_TX_TIMEOUT_EN
               else if (r_wait_cnt == WAIT_W'(GNT_TIMEOUT - 1)) begin
                  r_state      <= S_GAP;
                  r_frame      <= 1'b0;
                  r_data       <= 1'b0;
                  r_byte_ready <= 1'b0;
                  r_abort      <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
               end
`endif
            end
            S_DATA: begin
               if (r_bit_cnt == 3'd7) begin
                  r_byte_ready <= 1'b0;
                  if (w_last) begin
                     r_state <= S_GAP;
                     r_frame <= 1'b0;
                     r_data  <= 1'b0;
                     r_done  <= 1'b1;
                  end else if (w_take) begin
                     r_buf      <= i_byte;
                     r_data     <= i_byte[0];
                     r_bit_cnt  <= 3'd0;
                     r_byte_cnt <= r_byte_cnt + 4'd1;
                  end else begin
                     r_state    <= S_GAP;
                     r_frame    <= 1'b0;
                     r_data     <= 1'b0;
                     r_underrun <= 1'b1;
                  end
               end else begin
                  r_buf     <= r_buf >> 1;
                  r_data    <= r_buf[1];
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  // Open the next-byte window for the bit-7 cycle only.
                  if (r_bit_cnt == 3'd6) r_byte_ready <= !w_last;
               end
            end
            S_GAP: begin
               r_buf_vld <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_byte_ready = r_byte_ready;
   assign o_frame      = r_frame;
   assign o_data       = r_data;
   assign o_busy       = (r_state != S_IDLE);
   assign o_done       = r_done;
   assign o_underrun   = r_underrun;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_router_src_tx.sv
// Bench for router_src_tx: expected serial bits are queued per packet and
// compared against the captured frame; byte source runs as a background process.
module tb_router_src_tx;

   localparam int TMO = 4;

   logic       clk;
   logic       reset_n;
   logic       i_start;
   logic [1:0] i_dst;
   logic [3:0] i_len;
   logic [7:0] i_byte;
   logic       i_byte_valid;
   logic       o_byte_ready;
   logic       i_gnt;
   logic       o_frame;
   logic       o_data;
   logic       o_busy;
   logic       o_done;
   logic       o_underrun;
   logic       o_abort;
   logic [2:0] o_dbg_state;

   router_src_tx #(.GNT_TIMEOUT(TMO)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_start      (i_start),
      .i_dst        (i_dst),
      .i_len        (i_len),
      .i_byte       (i_byte),
      .i_byte_valid (i_byte_valid),
      .o_byte_ready (o_byte_ready),
      .i_gnt        (i_gnt),
      .o_frame      (o_frame),
      .o_data       (o_data),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_underrun   (o_underrun),
      .o_abort      (o_abort),
      .o_dbg_state  (o_dbg_state)
   );

   logic [7:0] src_q[$];
   logic [7:0] pkt_q[$];
   logic [0:0] exp_q[$];
   logic [0:0] got_q[$];
   int n_checks;
   int n_pass;
   int hs_cnt;
   int gnt_wait;
   int cap_len;
   logic cap_done, cap_und, cap_abt, cap_busy, cap_to;

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   // Byte source: presents src_q head, pops on handshake
   initial begin
      hs_cnt = 0;
      i_byte_valid = 1'b0;
      i_byte = 8'h00;
      forever begin
         @(posedge clk);
         if (i_byte_valid && o_byte_ready && src_q.size() > 0) begin
            i_byte = src_q.pop_front();
            hs_cnt++;
         end
         #1;
         i_byte_valid = (src_q.size() > 0);
         i_byte = (src_q.size() > 0) ? src_q[0] : 8'h00;
      end
   end

   task automatic send_start(input logic [1:0] dst, input logic [3:0] len);
      @(posedge clk);
      #1;
      i_start = 1'b1;
      i_dst = dst;
      i_len = len;
      @(posedge clk);
      #1;
      i_start = 1'b0;
   endtask

   task automatic push_exp(input logic [1:0] dst, input int waits, input int nbytes);
      exp_q.push_back(dst[0]);
      exp_q.push_back(dst[1]);
      for (int i = 0; i < waits; i++) exp_q.push_back(1'b0);
      for (int b = 0; b < nbytes; b++)
         for (int k = 0; k < 8; k++) exp_q.push_back(pkt_q[b][k]);
   endtask

   // Collect o_data while o_frame is high; GAP-cycle flags sampled after it falls.
   task automatic capture_frame(input int max_cycles);
      int n;
      got_q.delete();
      cap_len = 0;
      cap_to = 1'b0;
      n = 0;
      @(negedge clk);
      while (!o_frame && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      while (o_frame && cap_len < max_cycles) begin
         got_q.push_back(o_data);
         cap_len++;
         @(negedge clk);
      end
      cap_to = o_frame;
      cap_done = o_done;
      cap_und = o_underrun;
      cap_abt = o_abort;
      cap_busy = o_busy;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #2;
      n_checks++;
      if ({o_frame, o_data, o_byte_ready, o_busy, o_done, o_underrun, o_abort} !== 7'b0)
         $display("FAIL reset_outputs: got %b exp 0000000",
                  {o_frame, o_data, o_byte_ready, o_busy, o_done, o_underrun, o_abort});
      else n_pass++;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({o_frame, o_busy, o_byte_ready} !== 3'b0)
         $display("FAIL reset_idle: got %b exp 000", {o_frame, o_busy, o_byte_ready});
      else n_pass++;
   endtask

   task automatic test_basic();
      int hs0;
      i_gnt = 1'b1;
      pkt_q.delete();
      pkt_q.push_back(8'hA5);
      src_q = pkt_q;
      hs0 = hs_cnt;
      push_exp(2'd2, 1, 1);
      send_start(2'd2, 4'd1);
      capture_frame(40);
      n_checks++;
      if (cap_to !== 1'b0 || cap_len != 11)
         $display("FAIL basic_len: got %0d (timeout %b) exp 11", cap_len, cap_to);
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL basic_bit%0d: got %b exp %b", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      exp_q.delete();
      n_checks++;
      if ({cap_done, cap_und, cap_abt, cap_busy} !== 4'b1001)
         $display("FAIL basic_gap: got done/und/abt/busy %b exp 1001",
                  {cap_done, cap_und, cap_abt, cap_busy});
      else n_pass++;
      n_checks++;
      if (hs_cnt - hs0 != 1) $display("FAIL basic_handshakes: got %0d exp 1", hs_cnt - hs0);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({o_busy, o_done} !== 2'b00)
         $display("FAIL basic_idle_after_gap: got busy/done %b exp 00", {o_busy, o_done});
      else n_pass++;
   endtask

   task automatic test_len0_late_gnt();
      int hs0;
      i_gnt = 1'b0;
      pkt_q.delete();
      src_q.delete();
      src_q.push_back(8'h77);
      hs0 = hs_cnt;
      push_exp(2'd1, 5, 0);
      send_start(2'd1, 4'd0);
      gnt_wait = 5;
      fork
         begin
            repeat (gnt_wait + 1) @(posedge clk);
            #1 i_gnt = 1'b1;
            repeat (3) @(posedge clk);
            #1 i_gnt = 1'b0;
         end
      join_none
      capture_frame(40);
      n_checks++;
      if (cap_to !== 1'b0 || cap_len != 7)
         $display("FAIL len0_len: got %0d (timeout %b) exp 7", cap_len, cap_to);
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL len0_bit%0d: got %b exp %b", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      exp_q.delete();
      n_checks++;
      if ({cap_done, cap_und, cap_abt} !== 3'b100)
         $display("FAIL len0_gap: got done/und/abt %b exp 100", {cap_done, cap_und, cap_abt});
      else n_pass++;
      n_checks++;
      if (hs_cnt != hs0) $display("FAIL len0_no_handshake: got %0d exp 0", hs_cnt - hs0);
      else n_pass++;
      repeat (4) @(posedge clk);
      src_q.delete();
   endtask

   task automatic test_underrun();
      int hs0;
      i_gnt = 1'b1;
      pkt_q.delete();
      pkt_q.push_back(8'h3C);
      src_q = pkt_q;
      hs0 = hs_cnt;
      push_exp(2'd3, 1, 1);
      send_start(2'd3, 4'd3);
      capture_frame(60);
      n_checks++;
      if (cap_to !== 1'b0 || cap_len != 11)
         $display("FAIL under_len: got %0d (timeout %b) exp 11", cap_len, cap_to);
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL under_bit%0d: got %b exp %b", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      exp_q.delete();
      n_checks++;
      if ({cap_done, cap_und, cap_abt} !== 3'b010)
         $display("FAIL under_gap: got done/und/abt %b exp 010", {cap_done, cap_und, cap_abt});
      else n_pass++;
      src_q.push_back(8'hEE);
      repeat (4) @(posedge clk);
      n_checks++;
      if (hs_cnt - hs0 != 1) $display("FAIL under_no_more_bytes: got %0d exp 1", hs_cnt - hs0);
      else n_pass++;
      src_q.delete();
      repeat (2) @(posedge clk);
      // Byte 0 never arrives before the grant: cut short straight from the wait state.
      push_exp(2'd0, 1, 0);
      send_start(2'd0, 4'd1);
      capture_frame(40);
      n_checks++;
      if (cap_to !== 1'b0 || cap_len != 3 || {cap_done, cap_und} !== 2'b01)
         $display("FAIL under_wait: got len %0d done/und %b exp len 3 done/und 01",
                  cap_len, {cap_done, cap_und});
      else n_pass++;
      exp_q.delete();
   endtask

   task automatic test_start_ignored();
      i_gnt = 1'b1;
      pkt_q.delete();
      pkt_q.push_back(8'h96);
      src_q = pkt_q;
      push_exp(2'd1, 1, 1);
      send_start(2'd1, 4'd1);
      fork
         begin
            repeat (5) @(posedge clk);
            #1 begin i_start = 1'b1; i_dst = 2'd3; i_len = 4'd0; end
            @(posedge clk);
            #1 i_start = 1'b0;
            repeat (5) @(posedge clk);
            #1 i_start = 1'b1;
            repeat (2) @(posedge clk);
            #1 i_start = 1'b0;
         end
      join_none
      capture_frame(40);
      n_checks++;
      if (cap_to !== 1'b0 || cap_len != 11 || cap_done !== 1'b1)
         $display("FAIL ign_first: got len %0d done %b exp len 11 done 1", cap_len, cap_done);
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL ign_bit%0d: got %b exp %b", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      exp_q.delete();
      @(negedge clk);
      n_checks++;
      if ({o_frame, o_busy} !== 2'b00)
         $display("FAIL ign_gap_start: got frame/busy %b exp 00", {o_frame, o_busy});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({o_frame, o_busy, o_data} !== 3'b111)
         $display("FAIL ign_restart: got frame/busy/data %b exp 111", {o_frame, o_busy, o_data});
      else n_pass++;
      capture_frame(20);
      n_checks++;
      if (cap_len != 2 || got_q.size() != 2 || cap_done !== 1'b1)
         $display("FAIL ign_second: got len %0d done %b exp len 2 done 1", cap_len, cap_done);
      else if (got_q[0] !== 1'b1 || got_q[1] !== 1'b0)
         $display("FAIL ign_second_bits: got %b%b exp 10", got_q[0], got_q[1]);
      else n_pass++;
   endtask

   task automatic test_random_packets();
      logic [3:0] lens[3];
      logic [1:0] dst;
      int hs0;
      lens[0] = 4'd15;
      lens[1] = 4'd2;
      lens[2] = 4'($urandom_range(1, 14));
      for (int it = 0; it < 3; it++) begin
         repeat (3) @(posedge clk);
         i_gnt = 1'b0;
         dst = 2'($urandom_range(0, 3));
         gnt_wait = $urandom_range(1, 4);
         pkt_q.delete();
         for (int b = 0; b < int'(lens[it]); b++) pkt_q.push_back(8'($urandom_range(0, 255)));
         src_q = pkt_q;
         hs0 = hs_cnt;
         push_exp(dst, gnt_wait, int'(lens[it]));
         send_start(dst, lens[it]);
         fork
            begin
               repeat (gnt_wait + 1) @(posedge clk);
               #1 i_gnt = 1'b1;
               repeat (3) @(posedge clk);
               #1 i_gnt = 1'b0;
            end
         join_none
         capture_frame(200);
         n_checks++;
         if (cap_to !== 1'b0 || cap_len != 2 + gnt_wait + 8 * int'(lens[it]))
            $display("FAIL rand%0d_len: got %0d exp %0d", it, cap_len,
                     2 + gnt_wait + 8 * int'(lens[it]));
         else n_pass++;
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i])
               $display("FAIL rand%0d_bit%0d: got %b exp %b", it, i, got_q[i], exp_q[i]);
            else n_pass++;
         end
         exp_q.delete();
         n_checks++;
         if ({cap_done, cap_und, cap_abt} !== 3'b100 || hs_cnt - hs0 != int'(lens[it]))
            $display("FAIL rand%0d_end: got done/und/abt %b bytes %0d exp 100 bytes %0d",
                     it, {cap_done, cap_und, cap_abt}, hs_cnt - hs0, lens[it]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      logic quiet;
      i_gnt = 1'b1;
      pkt_q.delete();
      pkt_q.push_back(8'hF0);
      pkt_q.push_back(8'h0F);
      src_q = pkt_q;
      send_start(2'd0, 4'd2);
      repeat (7) @(posedge clk);
      #2;
      n_checks++;
      if ({o_frame, o_data} !== 2'b11)
         $display("FAIL rstmid_bit4: got frame/data %b exp 11", {o_frame, o_data});
      else n_pass++;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({o_frame, o_data, o_busy, o_byte_ready} !== 4'b0)
         $display("FAIL rstmid_async: got frame/data/busy/ready %b exp 0000",
                  {o_frame, o_data, o_busy, o_byte_ready});
      else n_pass++;
      src_q.delete();
      quiet = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if ({o_frame, o_busy, o_done, o_underrun, o_abort} !== 5'b0) quiet = 1'b0;
      end
      @(posedge clk);
      #2 reset_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if ({o_frame, o_busy, o_done, o_underrun, o_abort} !== 5'b0) quiet = 1'b0;
      end
      n_checks++;
      if (quiet !== 1'b1) $display("FAIL rstmid_quiet: got activity after reset exp none");
      else n_pass++;
   endtask

   task automatic test_grant_timeout();
      logic held;
      i_gnt = 1'b0;
      src_q.delete();
      pkt_q.delete();
`ifdef ROUTER_SRC_TX_TIMEOUT_EN
      push_exp(2'd1, TMO, 0);
      send_start(2'd1, 4'd0);
      capture_frame(40);
      n_checks++;
      if (cap_to !== 1'b0 || cap_len != 2 + TMO)
         $display("FAIL tmo_len: got %0d exp %0d", cap_len, 2 + TMO);
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL tmo_bit%0d: got %b exp %b", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      exp_q.delete();
      n_checks++;
      if ({cap_done, cap_und, cap_abt} !== 3'b001)
         $display("FAIL tmo_gap: got done/und/abt %b exp 001", {cap_done, cap_und, cap_abt});
      else n_pass++;
      held = 1'b1;
`else
      send_start(2'd1, 4'd0);
      held = 1'b1;
      repeat (80) begin
         @(negedge clk);
         if (o_frame !== 1'b1 || o_abort !== 1'b0 || o_busy !== 1'b1) held = 1'b0;
      end
      n_checks++;
      if (held !== 1'b1) $display("FAIL notmo_held: got frame dropped or abort exp held");
      else n_pass++;
      @(posedge clk);
      #1 i_gnt = 1'b1;
      capture_frame(10);
      i_gnt = 1'b0;
      n_checks++;
      if (cap_to !== 1'b0 || {cap_done, cap_und, cap_abt} !== 3'b100)
         $display("FAIL notmo_gap: got done/und/abt %b exp 100", {cap_done, cap_und, cap_abt});
      else n_pass++;
`endif
   endtask

   initial begin
      n_checks = 0;
      n_pass = 0;
      i_start = 1'b0;
      i_dst = 2'd0;
      i_len = 4'd0;
      i_gnt = 1'b0;
      gnt_wait = 1;
      test_reset();
      test_basic();
      test_len0_late_gnt();
      test_underrun();
      test_start_ignored();
      test_random_packets();
      test_reset_mid();
      test_grant_timeout();
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
